pixie_fb_arbiter: RTL and testbench
===================================

// Module: pixie_fb_arbiter
// PURPOSE
//  Shares the single-port Pixie framebuffer RAM between three users:
//  - the display back end (fixed-timing reads, never stalled)
//  - CPU/DMA accesses (req/ack handshake)
//  - a built-in clear sequencer (fills the RAM with one value)
//  Sits between the 1802 bus glue, the display back end and the framebuffer BRAM.
// PARAMETERS
//  ADDR_W  10  framebuffer address width; clear covers 2**ADDR_W bytes
//  DATA_W  8   framebuffer data width
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  disp_rd_en in   1       display read strobe, one cycle
//  disp_addr  in   ADDR_W  display read address
//  disp_data  out  DATA_W  display read data, valid the cycle after disp_rd_en
//  cpu_req    in   1       CPU access request; level, held until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read; stable while cpu_req
//  cpu_addr   in   ADDR_W  CPU address; stable while cpu_req
//  cpu_wdata  in   DATA_W  CPU write data; stable while cpu_req
//  cpu_ack    out  1       one-cycle access-complete pulse
//  cpu_rdata  out  DATA_W  CPU read data; valid when cpu_ack=1, held after
//  clr_start  in   1       start-clear pulse
//  clr_value  in   DATA_W  fill value; sampled with clr_start
//  clr_busy   out  1       clear in progress
//  ram_addr   out  ADDR_W  BRAM address (combinational mux)
//  ram_we     out  1       BRAM write enable (combinational)
//  ram_wdata  out  DATA_W  BRAM write data (combinational)
//  ram_q      in   DATA_W  BRAM read data, 1-cycle synchronous read latency
// BEHAVIOUR
//  - Reset: all registers clear and any clear/CPU transaction is aborted.
//    - cpu_ack=0, cpu_rdata=0, clr_busy=0, disp_data=0.
//    - ram_we is forced to 0 while reset=1.
//  - Per-cycle RAM owner, in priority order:
//    1. display, if disp_rd_en=1
//    2. clear, if clr_busy=1
//    3. CPU, if state C_IDLE, cpu_req=1, clr_busy=0 and clr_start=0
//    4. otherwise idle: ram_we=0, ram_addr=disp_addr
//  - Display path:
//    - Owned cycle: ram_addr=disp_addr, ram_we=0.
//    - Next cycle: disp_data=ram_q combinationally, and disp_hold<=ram_q.
//    - All other cycles: disp_data=disp_hold.
//  - CPU FSM states:
//    - C_IDLE: on CPU ownership, drive cpu_addr; ram_we=cpu_we, ram_wdata=cpu_wdata.
//      Move to C_ISSUED.
//    - C_ISSUED: if read, cpu_rdata<=ram_q. Move to C_ACK. The RAM is free this cycle.
//    - C_ACK: cpu_ack=1 (registered), then return to C_IDLE.
//    - Latency is grant+2 cycles for both reads and writes.
//    - If the requester keeps cpu_req high in C_ACK, it is a new request, evaluated in C_IDLE.
//    - A CPU transaction already in C_ISSUED/C_ACK completes normally when a clear starts.
//  - Clear sequencer:
//    - clr_start while clr_busy=0: clr_busy<=1, clr_cnt<=0, fill<=clr_value.
//    - clr_start while clr_busy=1 is ignored; the fill value is unchanged.
//    - Clear-owned cycle: ram_addr=clr_cnt, ram_we=1, ram_wdata=fill, clr_cnt<=clr_cnt+1.
//    - Cycle with disp_rd_en=1: clear stalls and clr_cnt holds.
//    - After writing address 2**ADDR_W-1, clr_busy<=0. clr_cnt wraps to 0 and is not reused.
//    - Best case 2**ADDR_W cycles; +1 cycle per display read stolen.
//  - Simultaneous events:
//    - clr_start with cpu_req in C_IDLE: the CPU is not granted, and waits until the clear ends.
//    - disp_rd_en with a clear or CPU grant: display wins; the loser retries next cycle.
// TESTING
//  1. CPU write then read:
//     - Write addr 0x155=0xA5, no display reads: cpu_ack 2 cycles after the grant.
//     - Read 0x155: cpu_rdata=0xA5 with cpu_ack.
//  2. Display priority:
//     - cpu_req and disp_rd_en both high, disp_addr=0x155: ram_we=0 that cycle.
//     - disp_data=0xA5 next cycle; the CPU is granted the following cycle.
//  3. Clear:
//     - clr_start with clr_value=0x00, disp_rd_en every 8th cycle: clr_busy high
//       for 1024+stolen cycles.
//     - Every address then reads 0x00; disp_data is correct throughout.
//  4. CPU during clear:
//     - cpu_req asserted mid-clear: no grant until the cycle after clr_busy falls.
//     - The CPU write is not overwritten.
//  5. Reset mid-operation:
//     - reset in C_ISSUED and mid-clear: no ack, clr_busy=0, ram_we=0 next cycle.
//     - A new CPU request afterwards completes.
//  6. Ignored restart:
//     - clr_start with 0xFF while busy: the fill stays at the original value and the count is not restarted.

Source files
------------

// File: rtl/pixie_fb_arbiter.sv
// Arbitrates the single-port Pixie framebuffer RAM between display reads,
// CPU/DMA req/ack accesses and a fill-the-whole-RAM clear sequencer.
module pixie_fb_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_rd_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_ISSUED = 2'd1,
    C_ACK    = 2'd2
  } cpu_state_e;

  cpu_state_e        state_q, state_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              disp_pend_q, disp_pend_d;
  logic [DATA_W-1:0] disp_hold_q, disp_hold_d;
  logic              clr_busy_q, clr_busy_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              clr_own;
  logic              cpu_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= C_IDLE;
      cpu_rd_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      disp_pend_q <= 1'b0;
      disp_hold_q <= '0;
      clr_busy_q  <= 1'b0;
      clr_cnt_q   <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      cpu_rd_q    <= cpu_rd_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      disp_pend_q <= disp_pend_d;
      disp_hold_q <= disp_hold_d;
      clr_busy_q  <= clr_busy_d;
      clr_cnt_q   <= clr_cnt_d;
      fill_q      <= fill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cpu_rd_d    = cpu_rd_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    disp_pend_d = disp_rd_en;
    disp_hold_d = disp_hold_q;
    clr_busy_d  = clr_busy_q;
    clr_cnt_d   = clr_cnt_q;
    fill_d      = fill_q;
    ram_addr    = disp_addr;
    ram_we      = 1'b0;
    ram_wdata   = '0;

    // Display always wins; a starting clear blocks a fresh CPU grant.
    clr_own   = clr_busy_q && !disp_rd_en;
    cpu_grant = (state_q == C_IDLE) && cpu_req && !clr_busy_q && !clr_start && !disp_rd_en;

    if (clr_own) begin
      ram_addr  = clr_cnt_q;
      ram_we    = 1'b1;
      ram_wdata = fill_q;
    end else if (cpu_grant) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end
    if (reset) begin
      ram_we = 1'b0;
    end

    if (disp_pend_q) begin
      disp_hold_d = ram_q;
    end
    disp_data = disp_pend_q ? ram_q : disp_hold_q;

    case (state_q)
      C_IDLE: begin
        if (cpu_grant) begin
          state_d  = C_ISSUED;
          cpu_rd_d = !cpu_we;
        end
      end
      C_ISSUED: begin
        if (cpu_rd_q) begin
          cpu_rdata_d = ram_q;
        end
        cpu_ack_d = 1'b1;
        state_d   = C_ACK;
      end
      C_ACK:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase

    if (clr_own) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == '1) begin
        clr_busy_d = 1'b0;
      end
    end else if (!clr_busy_q && clr_start) begin
      clr_busy_d = 1'b1;
      clr_cnt_d  = '0;
      fill_d     = clr_value;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign clr_busy  = clr_busy_q;

endmodule

// File: tb/tb_pixie_fb_arbiter.sv
// Randomized bench for pixie_fb_arbiter: a BRAM stand-in plus a
// transaction-level model of memory contents, CPU latency and clear progress.
module tb_pixie_fb_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              disp_rd_en = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic [DATA_W-1:0] disp_data;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              clr_start = 1'b0;
  logic [DATA_W-1:0] clr_value = '0;
  logic              clr_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q = '0;

  logic [DATA_W-1:0] tb_ram  [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;
  int disp_mode = 0;
  int disp_cyc = 0;

  int m_cd = 0;
  int m_cnt = 0;
  logic m_busy = 1'b0;
  logic m_wr = 1'b0;
  logic [DATA_W-1:0] m_fill = '0;
  logic [DATA_W-1:0] m_rd_val = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic [DATA_W-1:0] m_disp_val = '0;

  pixie_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .disp_rd_en(disp_rd_en), .disp_addr(disp_addr), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // BRAM stand-in with one-cycle read latency (read-before-write).
  always @(posedge clk) begin
    ram_q <= tb_ram[ram_addr];
    if (ram_we) tb_ram[ram_addr] = ram_wdata;
  end

  // Transaction-level reference: memory image, CPU completion countdown, clear progress.
  always @(posedge clk) begin
    if (reset) begin
      m_cd = 0; m_cnt = 0; m_busy = 1'b0; m_rdata = '0; m_disp_val = '0;
    end else begin
      if (disp_rd_en) m_disp_val = ref_mem[disp_addr];
      if (m_cd == 2 && !m_wr) m_rdata = m_rd_val;
      if (m_cd != 0) begin
        m_cd--;
      end else if (cpu_req && !disp_rd_en && !m_busy && !clr_start) begin
        m_cd = 2;
        m_wr = cpu_we;
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else m_rd_val = ref_mem[cpu_addr];
      end
      if (m_busy) begin
        if (!disp_rd_en) begin
          ref_mem[m_cnt] = m_fill;
          m_cnt++;
          if (m_cnt == DEPTH) m_busy = 1'b0;
        end
      end else if (clr_start) begin
        m_busy = 1'b1; m_cnt = 0; m_fill = clr_value;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("cpu_ack", 32'(cpu_ack), 32'(m_cd == 1));
      check_eq("clr_busy", 32'(clr_busy), 32'(m_busy));
      check_eq("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
      check_eq("disp_data", 32'(disp_data), 32'(m_disp_val));
    end
  end

  // Background display traffic: 1 = random, 2 = every 8th cycle.
  initial begin
    forever begin
      @(negedge clk);
      disp_cyc++;
      if (disp_mode == 1) begin
        disp_rd_en = ($urandom % 4) == 0;
        disp_addr  = ADDR_W'($urandom);
      end else if (disp_mode == 2) begin
        disp_rd_en = (disp_cyc % 8) == 0;
        disp_addr  = ADDR_W'($urandom);
      end
    end
  end

  task automatic cpu_xfer(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output int n);
    n = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack && n < 5000);
    check_eq("ack_seen", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic clr_pulse(input logic [DATA_W-1:0] v);
    @(negedge clk);
    clr_start = 1'b1; clr_value = v;
    @(negedge clk);
    clr_start = 1'b0;
  endtask

  task automatic wait_clear();
    int n = 0;
    while (clr_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("clr_done", 32'(clr_busy), 32'd0);
  endtask

  task automatic scan_all();
    disp_mode = 0;
    @(negedge clk);
    disp_rd_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      disp_rd_en = 1'b1;
      disp_addr = ADDR_W'(i);
    end
    @(negedge clk);
    disp_rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      tb_ram[i]  = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end

    @(negedge clk);
    chk_en = 1'b1;
    check_eq("rst_ack", 32'(cpu_ack), 32'd0);
    check_eq("rst_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("rst_busy", 32'(clr_busy), 32'd0);
    check_eq("rst_disp", 32'(disp_data), 32'd0);
    check_eq("rst_we", 32'(ram_we), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // CPU write then read, fixed grant+2 latency
    cpu_xfer(1'b1, 10'h155, 8'hA5, n);
    check_eq("wr_latency", 32'(n), 32'd2);
    cpu_xfer(1'b0, 10'h155, 8'h00, n);
    check_eq("rd_latency", 32'(n), 32'd2);
    check_eq("rd_155", 32'(cpu_rdata), 32'hA5);

    // Display beats a simultaneous CPU request
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0AA;
    disp_rd_en = 1'b1; disp_addr = 10'h155;
    #1;
    check_eq("prio_we", 32'(ram_we), 32'd0);
    check_eq("prio_addr", 32'(ram_addr), 32'h155);
    @(negedge clk);
    disp_rd_en = 1'b0;
    #1;
    check_eq("prio_disp", 32'(disp_data), 32'hA5);
    check_eq("prio_grant", 32'(ram_addr), 32'h0AA);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack && n < 10);
    check_eq("prio_ack_cyc", 32'(n), 32'd2);
    cpu_req = 1'b0;

    // Full clear to 0x00 with a display read stolen every 8th cycle
    disp_mode = 2;
    clr_pulse(8'h00);
    wait_clear();
    scan_all();

    // CPU write issued mid-clear must land after, and survive, the clear
    disp_mode = 2;
    clr_pulse(8'h5A);
    repeat (200) @(negedge clk);
    cpu_xfer(1'b1, 10'h0F0, 8'h3C, n);
    check_eq("mid_clr_busy", 32'(clr_busy), 32'd0);
    disp_mode = 0;
    @(negedge clk);
    disp_rd_en = 1'b0;
    cpu_xfer(1'b0, 10'h0F0, 8'h00, n);
    check_eq("mid_clr_rd", 32'(cpu_rdata), 32'h3C);

    // Reset with the CPU in C_ISSUED
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h2AB; cpu_wdata = 8'h77;
    @(negedge clk);
    cpu_req = 1'b0; reset = 1'b1;
    #1;
    check_eq("rst_iss_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_iss_ack", 32'(cpu_ack), 32'd0);

    // Reset mid-clear
    clr_pulse(8'h99);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_clr_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_clr_busy", 32'(clr_busy), 32'd0);
    #1;
    check_eq("rst_clr_we2", 32'(ram_we), 32'd0);
    cpu_xfer(1'b1, 10'h3FF, 8'hE1, n);
    check_eq("post_rst_lat", 32'(n), 32'd2);
    scan_all();

    // Restart while busy is ignored
    disp_mode = 2;
    clr_pulse(8'h22);
    repeat (50) @(negedge clk);
    clr_pulse(8'hFF);
    wait_clear();
    scan_all();

    // clr_start coincident with an idle CPU request
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h333; cpu_wdata = 8'hC3;
    clr_start = 1'b1; clr_value = 8'h44;
    #1;
    check_eq("coinc_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    while (!cpu_ack && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("coinc_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    cpu_xfer(1'b0, 10'h333, 8'h00, n);
    check_eq("coinc_rd", 32'(cpu_rdata), 32'hC3);

    // Random mix under random display traffic
    disp_mode = 1;
    for (int k = 0; k < 60; k++) begin
      if (($urandom % 10) == 0) clr_pulse(8'($urandom));
      else cpu_xfer(1'($urandom), ADDR_W'($urandom % 64), 8'($urandom), n);
    end
    wait_clear();
    scan_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
